pulse_measure: RTL and testbench



---
 rtl/pulse_measure_pkg.sv | 34 +++
 rtl/pulse_measure_if.sv | 19 +
 rtl/pulse_measure_sync_filter.sv | 71 +++++++
 rtl/pulse_measure.sv | 122 ++++++++++++
 tb/tb_pulse_measure.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pulse_measure_pkg.sv
// rtl/pulse_measure_pkg.sv - shared constants, state encoding and rounding helper for pulse_measure
//
// Purpose : OSCH clock constants, the default CLKS_PER_MS derived from them,
//           the measurement FSM encoding and bench timing constants.
// Ports   : none (package)

package pulse_measure_pkg;

  // OSCH internal oscillator frequency in Hz and cycles per millisecond.
  localparam int OSCH_FREQ       = 2080000;
  localparam int CLKS_PER_MS_DEF = OSCH_FREQ / 1000;

  // Timing constants for benches.
  localparam int MS_NS = 1000000;
  localparam int US_NS = 1000;

  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    ARM     = ST_ARM,
    IDLE    = ST_IDLE,
    MEASURE = ST_MEASURE,
    DONE    = ST_DONE
  } state_t;

  // Whole-ms count plus one when the leftover fraction is at least half a ms.
  function automatic logic [9:0] round_ms(input logic [8:0] ms, input logic round_up);
    return {1'b0, ms} + {9'd0, round_up};
  endfunction

endpackage

// File: rtl/pulse_measure_if.sv
// rtl/pulse_measure_if.sv - pulse input and measurement result bundle for pulse_measure
//
// Purpose : groups the pulse input with the measurement outputs.
// Signals : pulseIn (pulse input), pulseLength[7:0] (width in ms),
//           valid (one-cycle result strobe), overflow (width >= 255.5 ms),
//           busy (measurement in progress).
// Modports: master - drives pulseIn, observes results (bench / upstream)
//           slave  - the measuring block

interface pulse_measure_if;
  logic       pulseIn;
  logic [7:0] pulseLength;
  logic       valid;
  logic       overflow;
  logic       busy;

  modport master (output pulseIn, input pulseLength, valid, overflow, busy);
  modport slave  (input pulseIn, output pulseLength, valid, overflow, busy);
endinterface

// File: rtl/pulse_measure_sync_filter.sv
// rtl/pulse_measure_sync_filter.sv - synchroniser, optional glitch filter and edge detector
//
// Purpose : brings the asynchronous pulse into the masterClk domain and
//           produces its level plus single-cycle rise/fall indications.
// Ports   : masterClk, reset (sync, active high), pulse_in (async),
//           level (synchronised/filtered level), rise, fall (edge pulses).
// Macro   : PULSE_MEASURE_GLITCH_FILTER_EN inserts a stability filter
//           (GLITCH_CYCLES consecutive equal samples) after the synchroniser.

module pulse_measure_sync_filter
`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  #(parameter int GLITCH_CYCLES = 8)
`endif
  (
  input  logic masterClk,
  input  logic reset,
  input  logic pulse_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  // All stages reset high: a pin that is high at reset release then looks
  // like "already high" rather than producing a rising edge.
  always_ff @(posedge masterClk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
    end
  end

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  logic       filt;
  logic [7:0] gcnt;

  // Level follows sync2 only after GLITCH_CYCLES consecutive differing samples.
  always_ff @(posedge masterClk) begin
    if (reset) begin
      filt <= 1'b1;
      gcnt <= 8'd0;
    end else if (sync2 == filt) begin
      gcnt <= 8'd0;
    end else if (gcnt == 8'(GLITCH_CYCLES - 1)) begin
      filt <= sync2;
      gcnt <= 8'd0;
    end else begin
      gcnt <= gcnt + 8'd1;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge masterClk) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/pulse_measure.sv
// rtl/pulse_measure.sv - measures an active-high pulse width in rounded whole milliseconds
//
// Purpose : counts masterClk cycles while the pulse is high, reports the
//           width rounded to the nearest ms with a one-cycle valid strobe.
// Ports   : masterClk, reset (sync, active high),
//           pm (pulse_measure_if.slave: pulseIn, pulseLength, valid,
//           overflow, busy).
// Params  : CLKS_PER_MS (4..4095), GLITCH_CYCLES (1..255, only with the filter).
// Macro   : PULSE_MEASURE_GLITCH_FILTER_EN enables the input glitch filter.

module pulse_measure
  import pulse_measure_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEF
`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  , parameter int GLITCH_CYCLES = 8
`endif
) (
  input  logic            masterClk,
  input  logic            reset,
  pulse_measure_if.slave  pm
);

  logic        level, rise, fall;
  state_t      state, state_nx;
  logic [11:0] prescaler;
  logic [8:0]  ms_cnt;
  logic        clear_cnt;
  logic        pre_tc;
  logic [9:0]  result;
  logic [7:0]  len_q;
  logic        ovf_q;
  logic        valid_q;

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  pulse_measure_sync_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_sync (
`else
  pulse_measure_sync_filter u_sync (
`endif
    .masterClk (masterClk),
    .reset     (reset),
    .pulse_in  (pm.pulseIn),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge masterClk) begin
    if (reset) state <= ARM;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clear_cnt = 1'b0;
    case (state)
      ARM:     if (!level) state_nx = IDLE;
      IDLE: begin
        if (rise) begin
          clear_cnt = 1'b1;
          state_nx  = MEASURE;
        end
      end
      MEASURE: if (fall) state_nx = DONE;
      DONE: begin
        // A rise seen here would be gone by the time IDLE looks, so take it now.
        if (rise) begin
          clear_cnt = 1'b1;
          state_nx  = MEASURE;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = ARM;
    endcase
  end

  assign pre_tc = (prescaler == 12'(CLKS_PER_MS - 1));

  // Counting also runs on the edge that leaves MEASURE, so a terminal count
  // coinciding with the fall lands in ms_cnt with the prescaler back at 0.
  always_ff @(posedge masterClk) begin
    if (reset || clear_cnt) begin
      prescaler <= 12'd0;
      ms_cnt    <= 9'd0;
    end else if (state == MEASURE) begin
      if (pre_tc) begin
        prescaler <= 12'd0;
        if (ms_cnt != 9'd256) ms_cnt <= ms_cnt + 9'd1;
      end else begin
        prescaler <= prescaler + 12'd1;
      end
    end
  end

  assign result = round_ms(ms_cnt, prescaler >= 12'(CLKS_PER_MS / 2));

  always_ff @(posedge masterClk) begin
    if (reset) begin
      len_q   <= 8'd0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state == DONE);
      if (state == DONE) begin
        if (result > 10'd255) begin
          len_q <= 8'd255;
          ovf_q <= 1'b1;
        end else begin
          len_q <= result[7:0];
          ovf_q <= 1'b0;
        end
      end
    end
  end

  assign pm.pulseLength = len_q;
  assign pm.overflow    = ovf_q;
  assign pm.valid       = valid_q;
  assign pm.busy        = (state == MEASURE);

endmodule

// File: tb/tb_pulse_measure.sv
// tb/tb_pulse_measure.sv - directed self-checking bench for pulse_measure

module tb_pulse_measure;

  localparam int CPM = 10;
`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  localparam int GC  = 8;
  localparam int LAT = 4 + GC;
`else
  localparam int LAT = 4;
`endif

  logic masterClk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int         valid_cnt = 0;
  int         valid_cyc = 0;
  logic [7:0] last_len;
  logic       last_ovf;

  pulse_measure_if pif ();

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
  pulse_measure #(.CLKS_PER_MS(CPM), .GLITCH_CYCLES(GC)) dut (
`else
  pulse_measure #(.CLKS_PER_MS(CPM)) dut (
`endif
    .masterClk (masterClk),
    .reset     (reset),
    .pm        (pif.slave)
  );

  always #5 masterClk = ~masterClk;

  always @(posedge masterClk) cyc <= cyc + 1;

  always @(negedge masterClk) begin
    if (pif.valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      last_len  = pif.pulseLength;
      last_ovf  = pif.overflow;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge masterClk);
    #1;
  endtask

  // Drives an n-cycle high pulse and checks the reported result.
  task automatic measure(input string tag, input int n, input int exp_len, input logic exp_ovf);
    int v0;
    int fall_cyc;
    bit got;
    v0 = valid_cnt;
    pif.pulseIn = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (i == n / 2 && n >= 2 * (LAT + 2)) check({tag, ".busy"}, 32'(pif.busy), 1);
    end
    pif.pulseIn = 1'b0;
    fall_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < LAT + 16 && !got; i++) begin
      tick(1);
      if (valid_cnt != v0) got = 1'b1;
    end
    check({tag, ".valid"}, 32'(got), 1);
    if (got) begin
      check({tag, ".len"}, 32'(last_len), 32'(exp_len));
      check({tag, ".ovf"}, 32'(last_ovf), 32'(exp_ovf));
      check({tag, ".lat"}, 32'(valid_cyc - fall_cyc), 32'(LAT));
    end
    tick(4);
    check({tag, ".once"}, 32'(valid_cnt - v0), 1);
  endtask

  initial begin
    int v0;
    bit saw_busy;

    // Reset with the input already high.
    reset = 1'b1;
    pif.pulseIn = 1'b1;
    tick(3);
    check("rst.len",   32'(pif.pulseLength), 0);
    check("rst.valid", 32'(pif.valid), 0);
    check("rst.ovf",   32'(pif.overflow), 0);
    check("rst.busy",  32'(pif.busy), 0);
    reset = 1'b0;
    tick(30);
    pif.pulseIn = 1'b0;
    tick(LAT + 6);
    check("arm.novalid", 32'(valid_cnt), 0);
    check("arm.nobusy",  32'(pif.busy), 0);
    measure("arm.second", 50, 5, 1'b0);
    check("arm.total", 32'(valid_cnt), 1);

    // Loopback sweep 1, 17, ..., 241 ms.
    for (int ms = 1; ms <= 241; ms += 16) begin
      tick(3);
      measure($sformatf("sweep%0d", ms), ms * CPM, ms, 1'b0);
    end

    // Rounding boundaries (half ms = 5 cycles).
`ifndef PULSE_MEASURE_GLITCH_FILTER_EN
    tick(3); measure("r0p4",  4,  0, 1'b0);
    tick(3); measure("r0p5",  5,  1, 1'b0);
    tick(3); measure("r0p6",  6,  1, 1'b0);
`endif
    tick(3); measure("r0p9",  9,  1, 1'b0);
    tick(3); measure("r1p4",  14, 1, 1'b0);
    tick(3); measure("r1p5",  15, 2, 1'b0);
    tick(3); measure("r10p4", 104, 10, 1'b0);
    tick(3); measure("r10p5", 105, 11, 1'b0);

    // Saturation and overflow.
    tick(3); measure("o300",   3000, 255, 1'b1);
    tick(3); measure("o2",     20,   2,   1'b0);
    tick(3); measure("o255p4", 2554, 255, 1'b0);
    tick(3); measure("o255",   2550, 255, 1'b0);
    tick(3); measure("o255p5", 2555, 255, 1'b1);

    // Reset 4 ms into a 20 ms pulse.
    tick(3);
    pif.pulseIn = 1'b1;
    tick(40);
    reset = 1'b1;
    tick(2);
    check("mid.len",   32'(pif.pulseLength), 0);
    check("mid.ovf",   32'(pif.overflow), 0);
    check("mid.valid", 32'(pif.valid), 0);
    check("mid.busy",  32'(pif.busy), 0);
    v0 = valid_cnt;
    reset = 1'b0;
    tick(10);
    check("mid.armbusy", 32'(pif.busy), 0);
    tick(148);
    pif.pulseIn = 1'b0;
    tick(LAT + 8);
    check("mid.novalid", 32'(valid_cnt - v0), 0);
    measure("mid.next", 70, 7, 1'b0);

`ifdef PULSE_MEASURE_GLITCH_FILTER_EN
    // Short glitch is filtered away.
    tick(3);
    v0 = valid_cnt;
    saw_busy = 1'b0;
    pif.pulseIn = 1'b1;
    tick(3);
    pif.pulseIn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (pif.busy) saw_busy = 1'b1;
    end
    check("glitch.busy",  32'(saw_busy), 0);
    check("glitch.valid", 32'(valid_cnt - v0), 0);

    // 12 ms pulse with a 2-cycle dropout in the middle.
    v0 = valid_cnt;
    pif.pulseIn = 1'b1;
    tick(60);
    pif.pulseIn = 1'b0;
    tick(2);
    pif.pulseIn = 1'b1;
    tick(60);
    pif.pulseIn = 1'b0;
    tick(LAT + 10);
    check("drop.count", 32'(valid_cnt - v0), 1);
    check("drop.len",   32'(last_len), 12);
`else
    saw_busy = 1'b0;
    check("idle.busy", 32'(pif.busy | saw_busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
